// File: rtl/imem_loader_if.sv
// Byte-stream input, IMEM word-write and status signals of the instruction-memory loader.
interface imem_loader_if #(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32
) ();
  logic                  start;
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  wr_en;
  logic [PC_WIDTH-1:0]   wr_addr;
  logic [INST_WIDTH-1:0] wr_data;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic                  cpu_hold;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, busy, done, error, cpu_hold
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data, busy, done, error, cpu_hold
  );
endinterface

// File: rtl/imem_loader.sv
// Loads IMEM from a byte stream: 4-byte LE word count, then N LE words; one write cycle per word.
// Outputs are registered; in_ready is high only while collecting bytes, so the source stalls during WRITE.
module imem_loader #(
  parameter int PC_WIDTH       = 32,
  parameter int INST_WIDTH     = 32,
  parameter int IMEM_DEPTH     = 1024,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic          clk,
  input logic          reset,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE, ERR} state_t;

  localparam int                  IW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0]       IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]         MAX_WORDS = 32'(IMEM_DEPTH / 4);
  localparam logic [PC_WIDTH-1:0] ADDR_STEP = PC_WIDTH'(4);

  state_t                state;
  state_t                nxt;
  logic [1:0]            byte_cnt;
  logic [IW-1:0]         idle_cnt;
  logic [INST_WIDTH-9:0] shreg;
  logic [31:0]           words_rem;
  logic [PC_WIDTH-1:0]   addr;
  logic                  accept;
  logic                  last_byte;
  logic                  timed_out;
  logic [INST_WIDTH-1:0] assembled;

  // shreg holds the previous three bytes; the newest byte lands on top, so the first byte ends in [7:0].
  assign accept    = bus.in_valid && bus.in_ready;
  assign last_byte = accept && (byte_cnt == 2'd3);
  assign assembled = {bus.in_data, shreg};
  assign timed_out = !accept && (idle_cnt == IDLE_LAST);

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE, ERR: begin
        if (bus.start) nxt = LEN;
      end
      LEN: begin
        if (last_byte) begin
          if (assembled == '0)             nxt = DONE;
          else if (assembled > MAX_WORDS)  nxt = ERR;
          else                             nxt = DATA;
        end else if (timed_out) begin
          nxt = ERR;
        end
      end
      DATA: begin
        if (last_byte)      nxt = WRITE;
        else if (timed_out) nxt = ERR;
      end
      WRITE: begin
        nxt = (words_rem == 32'd1) ? DONE : DATA;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      byte_cnt     <= '0;
      idle_cnt     <= '0;
      shreg        <= '0;
      words_rem    <= '0;
      addr         <= '0;
      bus.in_ready <= 1'b0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.error    <= 1'b0;
      bus.cpu_hold <= 1'b1;
    end else begin
      state        <= nxt;
      bus.in_ready <= (nxt == LEN) || (nxt == DATA);
      bus.busy     <= (nxt == LEN) || (nxt == DATA) || (nxt == WRITE);
      bus.done     <= (nxt == DONE);
      bus.error    <= (nxt == ERR);
      bus.cpu_hold <= (nxt != DONE);
      bus.wr_en    <= (nxt == WRITE);

      if (nxt == WRITE) begin
        bus.wr_addr <= addr;
        bus.wr_data <= assembled;
      end

      if ((nxt == LEN) && (state != LEN)) begin
        byte_cnt  <= '0;
        idle_cnt  <= '0;
        shreg     <= '0;
        words_rem <= '0;
        addr      <= '0;
      end else if ((state == LEN) || (state == DATA)) begin
        if (accept) begin
          byte_cnt <= byte_cnt + 2'd1;
          shreg    <= assembled[INST_WIDTH-1:8];
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + IW'(1);
        end
        if ((state == LEN) && last_byte) words_rem <= 32'(assembled);
      end else if (state == WRITE) begin
        words_rem <= words_rem - 32'd1;
        // The final word leaves the address on the last written slot rather than one past IMEM.
        if (words_rem != 32'd1) addr <= addr + ADDR_STEP;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (IMEM_DEPTH=1024, TIMEOUT_CYCLES=8).
module tb_imem_loader;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_loader_if #(.PC_WIDTH(32), .INST_WIDTH(32)) bus ();

  imem_loader #(.PC_WIDTH(32), .INST_WIDTH(32), .IMEM_DEPTH(1024), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wa.push_back(bus.wr_addr);
      wd.push_back(bus.wr_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    if (k == 20) begin
      errors++;
      $display("FAIL send_byte: in_ready=%b required 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (bus.wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b want 0", bus.wr_en); end
    checks++; if (bus.wr_addr !== 32'h0) begin errors++; $display("FAIL rst_wr_addr: got %h want 0", bus.wr_addr); end
    checks++; if (bus.wr_data !== 32'h0) begin errors++; $display("FAIL rst_wr_data: got %h want 0", bus.wr_data); end
    checks++; if ({bus.busy, bus.done, bus.error} !== 3'b000) begin errors++; $display("FAIL rst_status: got %b want 000", {bus.busy, bus.done, bus.error}); end
    checks++; if (bus.cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_cpu_hold: got %b want 1", bus.cpu_hold); end
    step();
    reset = 1'b0;
    repeat (3) step();
    checks++; if ({bus.busy, bus.in_ready, bus.cpu_hold} !== 3'b001) begin errors++; $display("FAIL idle_wait: got %b want 001", {bus.busy, bus.in_ready, bus.cpu_hold}); end
  endtask

  task automatic test_basic();
    wa.delete(); wd.delete();
    pulse_start();
    checks++; if ({bus.busy, bus.in_ready, bus.cpu_hold} !== 3'b111) begin errors++; $display("FAIL basic_len: got %b want 111", {bus.busy, bus.in_ready, bus.cpu_hold}); end
    send_word(32'h0000_0002);
    send_word(32'h0010_0513);
    checks++; if ({bus.wr_en, bus.in_ready} !== 2'b10) begin errors++; $display("FAIL basic_latency: wr_en,in_ready=%b want 10", {bus.wr_en, bus.in_ready}); end
    checks++; if (bus.wr_addr !== 32'h0 || bus.wr_data !== 32'h0010_0513) begin errors++; $display("FAIL basic_w0: got %h/%h want 0/00100513", bus.wr_addr, bus.wr_data); end
    send_word(32'h0020_0593);
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 32'h4 || bus.wr_data !== 32'h0020_0593) begin errors++; $display("FAIL basic_w1: got %b %h/%h want 1 4/00200593", bus.wr_en, bus.wr_addr, bus.wr_data); end
    step();
    checks++; if ({bus.done, bus.error, bus.cpu_hold, bus.busy, bus.wr_en} !== 5'b10000) begin errors++; $display("FAIL basic_done: got %b want 10000", {bus.done, bus.error, bus.cpu_hold, bus.busy, bus.wr_en}); end
    checks++; if (bus.wr_addr !== 32'h4 || bus.wr_data !== 32'h0020_0593) begin errors++; $display("FAIL basic_hold: got %h/%h want 4/00200593", bus.wr_addr, bus.wr_data); end
    checks++; if (wa.size() != 2) begin errors++; $display("FAIL basic_count: got %0d want 2", wa.size()); end
  endtask

  task automatic test_zero();
    wa.delete(); wd.delete();
    pulse_start();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL zero_clear: done=%b want 0", bus.done); end
    send_word(32'h0);
    checks++; if ({bus.done, bus.busy, bus.cpu_hold, bus.wr_en} !== 4'b1000) begin errors++; $display("FAIL zero_done: got %b want 1000", {bus.done, bus.busy, bus.cpu_hold, bus.wr_en}); end
    repeat (2) step();
    checks++; if (wa.size() != 0) begin errors++; $display("FAIL zero_writes: got %0d want 0", wa.size()); end
  endtask

  task automatic test_max();
    int bad = 0;
    wa.delete(); wd.delete();
    pulse_start();
    send_word(32'd256);
    for (int i = 0; i < 256; i++) send_word({8'hA5, 8'(i), 16'(i * 3)});
    step();
    checks++; if (wa.size() != 256) begin errors++; $display("FAIL max_count: got %0d want 256", wa.size()); end
    for (int i = 0; i < wa.size(); i++)
      if (wa[i] !== 32'(i * 4) || wd[i] !== {8'hA5, 8'(i), 16'(i * 3)}) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL max_sequence: %0d bad writes want 0", bad); end
    checks++; if (wa.size() > 0 && wa[wa.size()-1] !== 32'h3FC) begin errors++; $display("FAIL max_last: got %h want 3fc", wa[wa.size()-1]); end
    checks++; if ({bus.done, bus.error, bus.cpu_hold} !== 3'b100) begin errors++; $display("FAIL max_done: got %b want 100", {bus.done, bus.error, bus.cpu_hold}); end
  endtask

  task automatic test_over();
    wa.delete(); wd.delete();
    pulse_start();
    send_word(32'd257);
    checks++; if ({bus.error, bus.done, bus.cpu_hold, bus.in_ready, bus.busy} !== 5'b10100) begin errors++; $display("FAIL over_err: got %b want 10100", {bus.error, bus.done, bus.cpu_hold, bus.in_ready, bus.busy}); end
    repeat (3) step();
    checks++; if (wa.size() != 0) begin errors++; $display("FAIL over_writes: got %0d want 0", wa.size()); end
  endtask

  task automatic test_timeout();
    pulse_start();
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL to_clear: error=%b want 0", bus.error); end
    send_word(32'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (7) step();
    checks++; if ({bus.error, bus.busy} !== 2'b01) begin errors++; $display("FAIL to_early: err,busy=%b want 01", {bus.error, bus.busy}); end
    step();
    checks++; if ({bus.error, bus.busy, bus.cpu_hold} !== 3'b101) begin errors++; $display("FAIL to_fire: got %b want 101", {bus.error, bus.busy, bus.cpu_hold}); end
    wa.delete(); wd.delete();
    pulse_start();
    send_word(32'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (7) step();
    send_byte(8'h33);
    checks++; if ({bus.error, bus.busy} !== 2'b01) begin errors++; $display("FAIL to_saved: err,busy=%b want 01", {bus.error, bus.busy}); end
    send_byte(8'h44);
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_data !== 32'h4433_2211) begin errors++; $display("FAIL to_write: got %b %h want 1 44332211", bus.wr_en, bus.wr_data); end
    step();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL to_done: got %b want 1", bus.done); end
  endtask

  task automatic test_reset_mid();
    wa.delete(); wd.delete();
    pulse_start();
    send_word(32'd2);
    send_byte(8'hAA);
    send_byte(8'hBB);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hCC;
    #1 reset = 1'b1;
    #1;
    checks++; if ({bus.in_ready, bus.wr_en, bus.busy, bus.done, bus.error, bus.cpu_hold} !== 6'b000001) begin errors++; $display("FAIL mid_status: got %b want 000001", {bus.in_ready, bus.wr_en, bus.busy, bus.done, bus.error, bus.cpu_hold}); end
    checks++; if (bus.wr_addr !== 32'h0 || bus.wr_data !== 32'h0) begin errors++; $display("FAIL mid_bus: got %h/%h want 0/0", bus.wr_addr, bus.wr_data); end
    bus.in_valid = 1'b0;
    step();
    reset = 1'b0;
    repeat (2) step();
    checks++; if (wa.size() != 0) begin errors++; $display("FAIL mid_nowrite: got %0d want 0", wa.size()); end
    pulse_start();
    send_word(32'd1);
    send_word(32'h1122_3344);
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 32'h0 || bus.wr_data !== 32'h1122_3344) begin errors++; $display("FAIL mid_reload: got %b %h/%h want 1 0/11223344", bus.wr_en, bus.wr_addr, bus.wr_data); end
    step();
  endtask

  task automatic test_start_ignored();
    wa.delete(); wd.delete();
    pulse_start();
    send_word(32'd2);
    send_byte(8'h01);
    send_byte(8'h02);
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h04);
    send_word(32'hCAFE_F00D);
    step();
    checks++; if (wa.size() != 2) begin errors++; $display("FAIL ign_count: got %0d want 2", wa.size()); end
    checks++; if (wa.size() == 2 && (wd[0] !== 32'h0403_0201 || wa[1] !== 32'h4 || wd[1] !== 32'hCAFE_F00D)) begin errors++; $display("FAIL ign_data: got %h %h/%h want 04030201 4/cafef00d", wd[0], wa[1], wd[1]); end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL ign_done: got %b want 1", bus.done); end
    wa.delete(); wd.delete();
    pulse_start();
    checks++; if ({bus.done, bus.busy, bus.in_ready, bus.cpu_hold} !== 4'b0111) begin errors++; $display("FAIL restart: got %b want 0111", {bus.done, bus.busy, bus.in_ready, bus.cpu_hold}); end
    send_word(32'd1);
    send_word(32'h0BAD_BEEF);
    step();
    checks++; if (wa.size() != 1 || wa[0] !== 32'h0 || wd[0] !== 32'h0BAD_BEEF) begin errors++; $display("FAIL restart_write: n=%0d want 1 at 0 data 0badbeef", wa.size()); end
  endtask

  initial begin
    reset        = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    test_reset();
    test_basic();
    test_zero();
    test_max();
    test_over();
    test_timeout();
    test_reset_mid();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, meaning the IMEM byte-address width.
REQ-002 SHALL have parameter INST_WIDTH, default 32, meaning the instruction word width, always 4 bytes.
REQ-003 SHALL have parameter IMEM_DEPTH, default 1024, meaning the IMEM size in bytes; it is a multiple of 4.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning the maximum number of idle cycles allowed between accepted bytes.
REQ-005 clk  input  1  -- single clock; all state updates on its rising edge.
REQ-006 reset  input  1  -- asynchronous, active-high reset.
REQ-007 start  input  1  -- one-cycle pulse that begins a load.
REQ-008 in_valid  input  1  -- in_data holds a valid byte.
REQ-009 in_data  input  8  -- byte-stream data.
REQ-010 in_ready  output  1  -- loader can accept a byte this cycle.
REQ-011 wr_en  output  1  -- IMEM word-write strobe.
REQ-012 wr_addr  output  PC_WIDTH  -- byte address of the word (addr..addr+3).
REQ-013 wr_data  output  INST_WIDTH  -- word to write; IMEM stores bits [7:0] at addr (little endian).
REQ-014 busy  output  1  -- load in progress.
REQ-015 done  output  1  -- load completed successfully (sticky).
REQ-016 error  output  1  -- load aborted (sticky).
REQ-017 cpu_hold  output  1  -- holds the core in reset while IMEM is invalid.

Function
REQ-018 Stream format SHALL be: 4-byte little-endian word count N, followed by N instruction words of 4 bytes each, little endian.
REQ-019 A byte SHALL be accepted only in a cycle where in_valid && in_ready.
REQ-020 The FSM states SHALL be IDLE, LEN, DATA, WRITE, DONE, ERR.
REQ-021 In IDLE/DONE/ERR, start SHALL move the FSM to LEN and clear done, error, the address counter (to 0) and the byte counter.
REQ-022 start SHALL be ignored in LEN, DATA and WRITE.
REQ-023 in_ready SHALL be 1 in LEN and DATA only.
REQ-024 busy SHALL be 1 in LEN, DATA and WRITE.
REQ-025 LEN: on the 4th accepted byte, with N as the 32-bit assembled count:
- N==0 -> DONE.
- N > IMEM_DEPTH/4 -> ERR.
- otherwise -> DATA.
REQ-026 N == IMEM_DEPTH/4 exactly SHALL be accepted.
REQ-027 DATA SHALL assemble bytes little endian: the 1st byte goes to word[7:0] and the 4th to word[31:24].
REQ-028 The 4th accepted byte in DATA SHALL move the FSM to WRITE.
REQ-029 WRITE SHALL last exactly one cycle, with wr_en=1, wr_addr=current address and wr_data=assembled word.
REQ-030 At the end of WRITE, the address SHALL increment by 4 and words-remaining SHALL decrement by 1.
REQ-031 After WRITE, the FSM SHALL go to DONE if words-remaining becomes 0, else back to DATA.
REQ-032 Latency from acceptance of a word's 4th byte to its wr_en SHALL be 1 cycle.
REQ-033 wr_en SHALL be 0 in all states other than WRITE.
REQ-034 wr_addr/wr_data SHALL hold their last values when wr_en=0.
REQ-035 Address arithmetic SHALL be PC_WIDTH-bit and SHALL never exceed IMEM_DEPTH-4.
REQ-036 The idle counter SHALL count consecutive LEN/DATA cycles with no accepted byte.
REQ-037 The idle counter SHALL reset on every accepted byte and on entry to LEN.
REQ-038 When the idle counter reaches TIMEOUT_CYCLES, the FSM SHALL go to ERR.
REQ-039 If a byte is accepted in the same cycle the timeout would fire, the byte SHALL take priority and no timeout occurs.
REQ-040 done SHALL be 1 only in DONE.
REQ-041 error SHALL be 1 only in ERR.
REQ-042 done and error SHALL never both be 1.
REQ-043 cpu_hold SHALL be 0 only in DONE; a failed or partial load keeps the core held.
REQ-044 Words already written before an abort SHALL NOT be rolled back.

Reset
REQ-045 While reset=1, outputs SHALL be asynchronously forced to:
- FSM=IDLE
- in_ready=0, wr_en=0, wr_addr=0, wr_data=0
- busy=0, done=0, error=0
- cpu_hold=1
- all counters 0.
REQ-046 Reset asserted mid-load SHALL abort immediately with no further wr_en.
REQ-047 After reset release, the loader SHALL wait in IDLE for start.

Verification
REQ-048 Stream N=2 (bytes 02 00 00 00), then 13 05 10 00 and 93 05 20 00 -> writes (0x0, 0x00100513) and (0x4, 0x00200593); done=1, cpu_hold=0.
REQ-049 N=0 -> DONE immediately after the 4th length byte, with no wr_en pulse.
REQ-050 With IMEM_DEPTH=1024:
- N=256 -> 256 writes, last at wr_addr 0x3FC, then DONE.
- N=257 -> ERR after the length, no writes, cpu_hold=1.
REQ-051 With TIMEOUT_CYCLES=8, stall in_valid after 2 data bytes -> ERR exactly 8 cycles after the last accepted byte; a byte arriving on cycle 8 prevents ERR.
REQ-052 Reset asserted during the 3rd byte of word 1 -> all outputs at reset values that cycle; a subsequent start reloads from address 0.
REQ-053 start pulsed during DATA is ignored; start in DONE clears done and reloads.
